// File: rtl/umi_pkg.sv
// Shared UMI definitions: opcode classes and the fixed packet field layout.
// Both the packer and the unpacker import this package, so the layout is
// defined in exactly one place.
//
// Packet layout (AW-bit addresses, 4*AW-bit packet):
//   [7:0]            opcode
//   [11:8]           size (log2 of transfer bytes)
//   [31:12]          user
//   [AW+31:32]       dstaddr
//   [2AW+31:AW+32]   srcaddr
//   [4AW-1:2AW+32]   data (2*AW-32 bits)
package umi_pkg;

  localparam int UMI_CMD_W      = 32;
  localparam int UMI_OPCODE_LSB = 0;
  localparam int UMI_OPCODE_W   = 8;
  localparam int UMI_SIZE_LSB   = 8;
  localparam int UMI_SIZE_W     = 4;
  localparam int UMI_USER_LSB   = 12;
  localparam int UMI_USER_W     = 20;
  localparam int UMI_DST_LSB    = UMI_CMD_W;

  // Opcode class is the low nibble of the opcode.
  typedef enum logic [3:0] {
    UMI_READ         = 4'h1,
    UMI_WRITE        = 4'h2,
    UMI_WRITE_POSTED = 4'h3,
    UMI_RESPONSE     = 4'h4
  } umi_class_e;

  function automatic int umi_src_lsb(input int aw);
    return aw + UMI_CMD_W;
  endfunction

  function automatic int umi_data_lsb(input int aw);
    return 2 * aw + UMI_CMD_W;
  endfunction

  // Payload width in bits for a given address width.
  function automatic int umi_dw(input int aw);
    return 2 * aw - UMI_CMD_W;
  endfunction

endpackage

// File: rtl/umi_unpack_if.sv
// Bus bundle for umi_unpack: the valid/ready packet input and the decoded,
// valid/ready field output.
//   slave  : the unpacker side (consumes in_*, produces decoded fields)
//   master : the environment side (produces in_*, consumes decoded fields)
interface umi_unpack_if
  import umi_pkg::*;
#(
  parameter int AW = 64
);
  localparam int DW = umi_dw(AW);

  logic              in_valid;
  logic [4*AW-1:0]   in_packet;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        opcode_out;
  logic [3:0]        size_out;
  logic [19:0]       user_out;
  logic [AW-1:0]     dstaddr_out;
  logic [AW-1:0]     srcaddr_out;
  logic [DW-1:0]     data_out;
  logic [DW/8-1:0]   strb_out;
  logic              cmd_read;
  logic              cmd_write;
  logic              cmd_err;
  logic [15:0]       err_count;

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, opcode_out, size_out, user_out,
           dstaddr_out, srcaddr_out, data_out, strb_out,
           cmd_read, cmd_write, cmd_err, err_count
  );

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, opcode_out, size_out, user_out,
           dstaddr_out, srcaddr_out, data_out, strb_out,
           cmd_read, cmd_write, cmd_err, err_count
  );

endinterface

// File: rtl/umi_decode.sv
// Combinational UMI packet decoder: splits the packet into fields, classifies
// the opcode and builds the byte strobe and the malformed-packet flag.
//   packet     : raw 4*AW-bit UMI packet
//   opcode..   : extracted fields
//   strb       : low 2**size lanes for data-carrying classes, all ones on
//                overflow, zero for reads and unknown classes
//   cmd_read   : READ class
//   cmd_write  : WRITE or WRITE_POSTED class
//   cmd_err    : unknown class or payload larger than DW/8 bytes
module umi_decode
  import umi_pkg::*;
#(
  parameter  int AW = 64,
  localparam int DW = umi_dw(AW),
  localparam int SW = DW / 8
) (
  input  logic [4*AW-1:0] packet,
  output logic [7:0]      opcode,
  output logic [3:0]      size,
  output logic [19:0]     user,
  output logic [AW-1:0]   dstaddr,
  output logic [AW-1:0]   srcaddr,
  output logic [DW-1:0]   data,
  output logic [SW-1:0]   strb,
  output logic            cmd_read,
  output logic            cmd_write,
  output logic            cmd_err
);

  umi_class_e  cls;
  logic [16:0] nbytes;

  assign opcode  = packet[UMI_OPCODE_LSB +: UMI_OPCODE_W];
  assign size    = packet[UMI_SIZE_LSB +: UMI_SIZE_W];
  assign user    = packet[UMI_USER_LSB +: UMI_USER_W];
  assign dstaddr = packet[UMI_DST_LSB +: AW];
  assign srcaddr = packet[umi_src_lsb(AW) +: AW];
  assign data    = packet[umi_data_lsb(AW) +: DW];

  assign cls    = umi_class_e'(opcode[3:0]);
  assign nbytes = 17'd1 << size;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned (which would infer a latch).
    strb      = '0;
    cmd_read  = 1'b0;
    cmd_write = 1'b0;
    cmd_err   = 1'b0;
    case (cls)
      UMI_READ: cmd_read = 1'b1;
      UMI_WRITE, UMI_WRITE_POSTED, UMI_RESPONSE: begin
        // RESPONSE carries data, so it gets a strobe, but it is not a write.
        cmd_write = (cls != UMI_RESPONSE);
        if (nbytes > 17'(SW)) begin
          strb    = '1;
          cmd_err = 1'b1;
        end else begin
          for (int i = 0; i < SW; i++) strb[i] = (17'(i) < nbytes);
        end
      end
      default: cmd_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/umi_unpack.sv
// UMI receive-side unpacker. Accepts packets on a valid/ready input, decodes
// them and presents registered fields on a valid/ready output. A 2-entry
// elastic buffer (output register + raw-packet skid register) sustains one
// packet per cycle while keeping in_ready registered.
//   clk, nreset : clock, asynchronous active-low reset
//   bus         : umi_unpack_if slave port (input packet, decoded outputs,
//                 saturating count of delivered errored packets)
module umi_unpack
  import umi_pkg::*;
#(
  parameter int AW = 64
) (
  input logic         clk,
  input logic         nreset,
  umi_unpack_if.slave bus
);

  localparam int DW = umi_dw(AW);
  localparam int SW = DW / 8;
  localparam int PW = 4 * AW;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  occ_e            state;
  logic [PW-1:0]   skid_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [7:0]      opcode_q;
  logic [3:0]      size_q;
  logic [19:0]     user_q;
  logic [AW-1:0]   dstaddr_q;
  logic [AW-1:0]   srcaddr_q;
  logic [DW-1:0]   data_q;
  logic [SW-1:0]   strb_q;
  logic            cmd_read_q;
  logic            cmd_write_q;
  logic            cmd_err_q;
  logic [15:0]     err_count_q;

  logic [PW-1:0]   dec_packet;
  logic [7:0]      dec_opcode;
  logic [3:0]      dec_size;
  logic [19:0]     dec_user;
  logic [AW-1:0]   dec_dstaddr;
  logic [AW-1:0]   dec_srcaddr;
  logic [DW-1:0]   dec_data;
  logic [SW-1:0]   dec_strb;
  logic            dec_read;
  logic            dec_write;
  logic            dec_err;

  logic in_xfer;
  logic out_xfer;
  logic load_out;

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  // In TWO the oldest waiting packet sits in the skid register; otherwise
  // the output register loads straight from the input.
  assign dec_packet = (state == TWO) ? skid_q : bus.in_packet;

  assign load_out = ((state == EMPTY) && in_xfer) ||
                    ((state == ONE) && in_xfer && out_xfer) ||
                    ((state == TWO) && out_xfer);

  umi_decode #(.AW(AW)) u_decode (
    .packet    (dec_packet),
    .opcode    (dec_opcode),
    .size      (dec_size),
    .user      (dec_user),
    .dstaddr   (dec_dstaddr),
    .srcaddr   (dec_srcaddr),
    .data      (dec_data),
    .strb      (dec_strb),
    .cmd_read  (dec_read),
    .cmd_write (dec_write),
    .cmd_err   (dec_err)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      // NOTE: the skid register is reset along with everything else; it is a
      // single entry, and a clean value keeps reset behaviour easy to reason
      // about.
      state       <= EMPTY;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      size_q      <= '0;
      user_q      <= '0;
      dstaddr_q   <= '0;
      srcaddr_q   <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (out_xfer && cmd_err_q && (err_count_q != 16'hFFFF))
        err_count_q <= err_count_q + 16'd1;

      if (load_out) begin
        opcode_q    <= dec_opcode;
        size_q      <= dec_size;
        user_q      <= dec_user;
        dstaddr_q   <= dec_dstaddr;
        srcaddr_q   <= dec_srcaddr;
        data_q      <= dec_data;
        strb_q      <= dec_strb;
        cmd_read_q  <= dec_read;
        cmd_write_q <= dec_write;
        cmd_err_q   <= dec_err;
      end

      case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q     <= bus.in_packet;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (!in_xfer && out_xfer) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.opcode_out  = opcode_q;
  assign bus.size_out    = size_q;
  assign bus.user_out    = user_q;
  assign bus.dstaddr_out = dstaddr_q;
  assign bus.srcaddr_out = srcaddr_q;
  assign bus.data_out    = data_q;
  assign bus.strb_out    = strb_q;
  assign bus.cmd_read    = cmd_read_q;
  assign bus.cmd_write   = cmd_write_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_umi_unpack.sv
// Testbench for umi_unpack at AW=64 (DW=96, 12 byte lanes). Directed cases
// plus randomized traffic checked against a transaction-level model: a queue
// of expected decoded packets and an occupancy count.
module tb_umi_unpack;

  localparam int AW = 64;

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  size;
    logic [19:0] user;
    logic [63:0] dst;
    logic [63:0] src;
    logic [95:0] data;
    logic [11:0] strb;
    logic        rd;
    logic        wr;
    logic        err;
  } pkt_t;

  logic clk = 1'b0;
  logic nreset;

  umi_unpack_if #(.AW(AW)) bus ();

  umi_unpack #(.AW(AW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected decode derived from the class/size rules with plain arithmetic.
  function automatic pkt_t mk(input logic [7:0] op, input logic [3:0] size,
                              input logic [19:0] user, input logic [63:0] dst,
                              input logic [63:0] src, input logic [95:0] data);
    pkt_t p;
    int   cls;
    int   n;
    p = '0;
    p.op = op; p.size = size; p.user = user;
    p.dst = dst; p.src = src; p.data = data;
    cls = int'(op) % 16;
    n   = 2 ** int'(size);
    if (cls == 1) begin
      p.rd = 1'b1;
    end else if (cls >= 2 && cls <= 4) begin
      p.wr = (cls != 4);
      if (n > 12) begin
        p.strb = 12'hFFF;
        p.err  = 1'b1;
      end else begin
        p.strb = 12'((2 ** n) - 1);
      end
    end else begin
      p.err = 1'b1;
    end
    return p;
  endfunction

  function automatic pkt_t rand_pkt();
    logic [7:0] op;
    logic [3:0] size;
    int sel;
    sel = int'($urandom_range(0, 5));
    op[7:4] = 4'($urandom);
    if (sel < 4)       op[3:0] = 4'(sel + 1);
    else if (sel == 4) op[3:0] = 4'h0;
    else               op[3:0] = 4'($urandom_range(5, 15));
    size = ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
    return mk(op, size, 20'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom, $urandom});
  endfunction

  // ---- reference model (updated at negedge, when everything is stable) ----
  pkt_t        cur;
  pkt_t        exp_q[$];
  int          occ = 0;
  int          delivered = 0;
  logic [15:0] err_model = '0;

  always @(negedge clk) begin
    pkt_t h;
    bit   acc;
    bit   oxf;
    if (!nreset) begin
      exp_q.delete();
      occ       = 0;
      err_model = '0;
    end else begin
      check("in_ready", bus.in_ready, occ < 2);
      check("out_valid", bus.out_valid, occ > 0);
      check("err_count", bus.err_count, err_model);
      h = '0;
      if (occ > 0) begin
        h = exp_q[0];
        check("opcode", bus.opcode_out, h.op);
        check("size", bus.size_out, h.size);
        check("user", bus.user_out, h.user);
        check("dstaddr", bus.dstaddr_out, h.dst);
        check("srcaddr", bus.srcaddr_out, h.src);
        check("data", bus.data_out, h.data);
        check("strb", bus.strb_out, h.strb);
        check("cmd_read", bus.cmd_read, h.rd);
        check("cmd_write", bus.cmd_write, h.wr);
        check("cmd_err", bus.cmd_err, h.err);
      end
      acc = bus.in_valid && (occ < 2);
      oxf = bus.out_ready && (occ > 0);
      if (oxf) begin
        delivered++;
        if (h.err && err_model != 16'hFFFF) err_model = err_model + 16'd1;
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(cur);
      occ = occ + int'(acc) - int'(oxf);
    end
  end

  // Present a packet and hold it until accepted; returns with time at #1
  // after the accepting edge. in_valid is left high for the caller.
  task automatic send(input pkt_t p, input bit rand_ready, output int waits);
    bit ok;
    bit done;
    bus.in_valid  = 1'b1;
    bus.in_packet = {p.data, p.src, p.dst, p.user, p.size, p.op};
    cur   = p;
    waits = 0;
    done  = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
      else begin
        waits++;
        if (rand_ready) bus.out_ready = 1'($urandom);
      end
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    int   w;
    int   tw;
    int   d0;

    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    cur           = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data", bus.data_out, 96'h0);
    check("rst_dstaddr", bus.dstaddr_out, 64'h0);
    check("rst_strb", bus.strb_out, 12'h0);
    check("rst_opcode", bus.opcode_out, 8'h0);
    check("rst_cmd_err", bus.cmd_err, 1'b0);
    check("rst_err_count", bus.err_count, 16'h0);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Single write.
    bus.out_ready = 1'b1;
    send(mk(8'h02, 4'd2, 20'h0, 64'h1000, 64'h0, 96'hAABBCCDD), 1'b0, w);
    check("wr_out_valid", bus.out_valid, 1'b1);
    check("wr_cmd_write", bus.cmd_write, 1'b1);
    check("wr_strb", bus.strb_out, 12'h00F);
    check("wr_data", bus.data_out, 96'hAABBCCDD);
    check("wr_dstaddr", bus.dstaddr_out, 64'h1000);
    bus.in_valid = 1'b0;

    // Read.
    send(mk(8'h01, 4'd3, 20'h0, 64'h0, 64'h2000, 96'h0), 1'b0, w);
    check("rd_cmd_read", bus.cmd_read, 1'b1);
    check("rd_strb", bus.strb_out, 12'h000);
    check("rd_srcaddr", bus.srcaddr_out, 64'h2000);
    check("rd_cmd_err", bus.cmd_err, 1'b0);
    bus.in_valid = 1'b0;

    // Payload overflow: 16 bytes into 12 lanes.
    send(mk(8'h02, 4'd4, 20'h0, 64'h3000, 64'h0, 96'h1), 1'b0, w);
    check("ovf_strb", bus.strb_out, 12'hFFF);
    check("ovf_cmd_err", bus.cmd_err, 1'b1);
    check("ovf_err_count_before", bus.err_count, 16'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ovf_err_count_after", bus.err_count, 16'd1);

    // Backpressure: out_ready low for three edges while streaming 5 packets.
    d0 = delivered;
    bus.out_ready = 1'b0;
    send(rand_pkt(), 1'b0, w);
    send(rand_pkt(), 1'b0, w);
    check("bp_in_ready_low", bus.in_ready, 1'b0);
    p = rand_pkt();
    bus.in_packet = {p.data, p.src, p.dst, p.user, p.size, p.op};
    cur = p;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(p, 1'b0, w);
    send(rand_pkt(), 1'b0, w);
    send(rand_pkt(), 1'b0, w);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_delivered", 32'(delivered - d0), 32'd5);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full throughput: one packet per cycle for 100 cycles.
    d0 = delivered;
    tw = 0;
    for (int i = 0; i < 100; i++) begin
      send(rand_pkt(), 1'b0, w);
      tw += w;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("tp_delivered", 32'(delivered - d0), 32'd100);
    check("tp_no_stall", 32'(tw), 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random gaps and random backpressure.
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) begin
        send(rand_pkt(), 1'b1, w);
      end else begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while both entries are full.
    bus.out_ready = 1'b0;
    send(rand_pkt(), 1'b0, w);
    send(rand_pkt(), 1'b0, w);
    check("two_in_ready_low", bus.in_ready, 1'b0);
    check("two_err_count_nonzero", bus.err_count != 16'd0, 1'b1);
    nreset       = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("mrst_out_valid", bus.out_valid, 1'b0);
    check("mrst_in_ready", bus.in_ready, 1'b1);
    check("mrst_err_count", bus.err_count, 16'd0);
    @(posedge clk);
    #1;
    nreset        = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mrst_no_output", bus.out_valid, 1'b0);
    check("mrst_delivered_none", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
